// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  // Saturate a load value into the count range 0..modulus-1.
  function automatic int unsigned clamp(input int unsigned value, input int unsigned modulus);
    return (value >= modulus) ? (modulus - 1) : value;
  endfunction

endpackage

// File: rtl/syn_up_counter.sv
// Synchronous modulo-N up counter with enable, parallel load and one-shot stop.
// q/busy/done update one clk edge after inputs are sampled; tc is combinational.
module syn_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  generate
    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
      $error("syn_up_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  cnt_state_t       state;
  cnt_state_t       state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             at_term;

  assign at_term = (q == TERM);
  assign tc      = busy & en & at_term & ~load & ~start;

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          q_nxt     = '0;
        end
      end
      RUN: begin
        if (start) begin
          q_nxt = '0;
        end else if (en && !load) begin
          // Terminal cycle: one_shot decides between stopping and wrapping.
          if (at_term) begin
            if (one_shot) state_nxt = DONE;
            else          q_nxt     = '0;
          end else begin
            q_nxt = q + 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          q_nxt     = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = '0;
      end
    endcase
    if (load) q_nxt = WIDTH'(clamp(32'(din), 32'(MODULUS)));
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_syn_up_counter.sv
// Directed bench: modulo-10 instance plus a two-stage modulo-16 cascade.
module tb_syn_up_counter;

  logic       clk = 1'b0;
  logic       res_n;
  logic       start, en, load, one_shot;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc, done, busy;

  logic       c_start, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_done, hi_done, lo_busy, hi_busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  syn_up_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .res_n(res_n), .start(start), .en(en), .load(load), .din(din),
    .one_shot(one_shot), .q(q), .tc(tc), .done(done), .busy(busy)
  );

  syn_up_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .res_n(res_n), .start(c_start), .en(c_en), .load(1'b0), .din(4'd0),
    .one_shot(1'b0), .q(lo_q), .tc(lo_tc), .done(lo_done), .busy(lo_busy)
  );

  syn_up_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .res_n(res_n), .start(c_start), .en(lo_tc), .load(1'b0), .din(4'd0),
    .one_shot(1'b0), .q(hi_q), .tc(hi_tc), .done(hi_done), .busy(hi_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int eq, input int etc, input int ebusy, input int edone);
    check({tag, ".q"},    32'(q),    32'(eq));
    check({tag, ".tc"},   32'(tc),   32'(etc));
    check({tag, ".busy"}, 32'(busy), 32'(ebusy));
    check({tag, ".done"}, 32'(done), 32'(edone));
  endtask

  initial begin
    res_n = 1'b0; start = 1'b0; en = 1'b0; load = 1'b0; one_shot = 1'b0; din = 4'd0;
    c_start = 1'b0; c_en = 1'b0;
    #1;

    // Reset held while inputs toggle randomly
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
      load  = 1'($urandom_range(0, 1)); din = 4'($urandom_range(0, 15));
      tick();
      check_all("reset_hold", 0, 0, 0, 0);
    end
    start = 1'b0; en = 1'b0; load = 1'b0; din = 4'd0;
    res_n = 1'b1;
    tick();
    check_all("after_reset", 0, 0, 0, 0);

    // Start, then free-run two full periods
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("start", 0, 0, 1, 0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_all("freerun", i % 10, (i % 10 == 9) ? 1 : 0, 1, 0);
      tick();
    end
    check("freerun_end.q", 32'(q), 32'd0);

    // Priority: start beats en at the terminal value
    repeat (9) tick();
    check("prio_at9.tc", 32'(tc), 32'd1);
    start = 1'b1;
    #1;
    check_all("prio_start_en", 9, 0, 1, 0);
    tick();
    start = 1'b0;
    check_all("prio_restart", 0, 0, 1, 0);
    repeat (3) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("hold_en0", 3, 0, 1, 0);
    end
    en = 1'b1;
    repeat (6) tick();
    en = 1'b0;
    #1;
    check_all("at9_en0", 9, 0, 1, 0);
    tick();
    check("at9_en0_hold.q", 32'(q), 32'd9);

    // Load and clamp while running
    load = 1'b1; din = 4'd5;
    tick();
    load = 1'b0;
    check_all("load5", 5, 0, 1, 0);
    load = 1'b1; din = 4'd14;
    tick();
    load = 1'b0;
    check_all("load14_clamp", 9, 0, 1, 0);
    en = 1'b1; load = 1'b1; one_shot = 1'b1;
    #1;
    check("load_blocks_tc.tc", 32'(tc), 32'd0);
    tick();
    load = 1'b0; en = 1'b0;
    check_all("load_no_done", 9, 0, 1, 0);

    // One-shot: stop at the terminal value, enter DONE
    start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    check_all("os_start", 0, 0, 1, 0);
    repeat (9) tick();
    check_all("os_term", 9, 1, 1, 0);
    tick();
    check_all("os_done", 9, 0, 0, 1);
    repeat (3) tick();
    check_all("os_done_hold", 9, 0, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("os_restart", 0, 0, 1, 0);

    // Asynchronous reset between edges at q==6
    one_shot = 1'b0;
    repeat (6) tick();
    check("pre_arst.q", 32'(q), 32'd6);
    #2;
    res_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0);
    en = 1'b0;
    tick();
    res_n = 1'b1;

    // IDLE: en ignored, load alone keeps IDLE, load+start enters RUN
    en = 1'b1;
    tick();
    check_all("idle_en", 0, 0, 0, 0);
    en = 1'b0; load = 1'b1; din = 4'd7;
    tick();
    load = 1'b0;
    check_all("idle_load", 7, 0, 0, 0);
    load = 1'b1; start = 1'b1; din = 4'd3;
    tick();
    load = 1'b0; start = 1'b0;
    check_all("load_start", 3, 0, 1, 0);

    // Cascade of two modulo-16 stages forms an 8-bit counter
    c_start = 1'b1; c_en = 1'b1;
    tick();
    c_start = 1'b0;
    for (int i = 0; i < 260; i++) begin
      check("cascade", 32'({hi_q, lo_q}), 32'(i % 256));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
